noc_switch_allocator: RTL

//  Control-side counterpart to the 5-port crossbarSwitch: arbitrates head-flit route requests

---
 rtl/noc_switch_allocator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/noc_switch_allocator.sv
// rtl/noc_switch_allocator.sv - 5-port switch allocator: per-output round-robin, wormhole lock, stall timeout
module noc_switch_allocator #(
    parameter logic [2:0] SEL_IDLE     = 3'b111,
    parameter int         LOCK_TIMEOUT = 255,
    parameter int         TO_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  req_valid,
    input  logic [14:0] req_dest,
    input  logic [4:0]  req_tail,
    input  logic [4:0]  out_ready,
    output logic [4:0]  grant,
    output logic [2:0]  N_port_select,
    output logic [2:0]  S_port_select,
    output logic [2:0]  E_port_select,
    output logic [2:0]  W_port_select,
    output logic [2:0]  L_port_select,
    output logic [4:0]  out_valid,
    output logic        uturn_err,
    output logic        timeout_pulse
);
    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(LOCK_TIMEOUT);
    localparam logic [TO_W-1:0] STALL_MAX = '1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t          state_q [5];
    state_t          state_d [5];
    logic [2:0]      owner_q [5];
    logic [2:0]      owner_d [5];
    logic [2:0]      rr_q    [5];
    logic [2:0]      rr_d    [5];
    logic [TO_W-1:0] stall_q [5];
    logic [TO_W-1:0] stall_d [5];

    logic [2:0] dest [5];
    logic [2:0] sel  [5];
    logic [4:0] busy;
    logic [4:0] fire;
    logic [4:0] to_hit;

    // Everything visible at the ports is a function of the lock state and this cycle's requests.
    always_comb begin
        busy      = '0;
        fire      = '0;
        to_hit    = '0;
        grant     = '0;
        uturn_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dest[i] = req_dest[3*i +: 3];
            if (req_valid[i] && (dest[i] == 3'(i) || dest[i] > 3'd4))
                uturn_err = 1'b1;
        end
        for (int o = 0; o < 5; o++) begin
            sel[o] = SEL_IDLE;
            if (state_q[o] == ST_LOCKED) begin
                sel[o]             = owner_q[o];
                busy[owner_q[o]]   = 1'b1;
                fire[o]            = req_valid[owner_q[o]] & out_ready[o];
                grant[owner_q[o]] |= fire[o];
                to_hit[o]          = (LOCK_TIMEOUT != 0) && !fire[o] && (stall_q[o] == TIMEOUT_V);
            end
        end
    end

    always_comb begin
        int         idx;
        logic       found;
        logic [2:0] win;
        for (int o = 0; o < 5; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            stall_d[o] = stall_q[o];
            found      = 1'b0;
            win        = '0;
            idx        = 0;
            if (state_q[o] == ST_IDLE) begin
                // Busy inputs are excluded so a released owner's next head waits one cycle.
                for (int k = 0; k < 5; k++) begin
                    idx = int'(rr_q[o]) + k;
                    if (idx >= 5)
                        idx = idx - 5;
                    if (!found && req_valid[idx] && dest[idx] == 3'(o) && idx != o && !busy[idx]) begin
                        found = 1'b1;
                        win   = 3'(idx);
                    end
                end
                if (found) begin
                    state_d[o] = ST_LOCKED;
                    owner_d[o] = win;
                    stall_d[o] = '0;
                end
            end else if ((fire[o] && req_tail[owner_q[o]]) || to_hit[o]) begin
                state_d[o] = ST_IDLE;
                rr_d[o]    = (owner_q[o] == 3'd4) ? 3'd0 : owner_q[o] + 3'd1;
                stall_d[o] = '0;
            end else if (fire[o]) begin
                stall_d[o] = '0;
            end else if (stall_q[o] != STALL_MAX) begin
                stall_d[o] = stall_q[o] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < 5; o++) begin
            if (!rst_n) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= '0;
                rr_q[o]    <= '0;
                stall_q[o] <= '0;
            end else begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
                stall_q[o] <= stall_d[o];
            end
        end
    end

    assign N_port_select = sel[0];
    assign S_port_select = sel[1];
    assign E_port_select = sel[2];
    assign W_port_select = sel[3];
    assign L_port_select = sel[4];
    assign out_valid     = fire;
    assign timeout_pulse = |to_hit;
endmodule
